// File: rtl/timer_pkg.sv
// Shared types and constants for the MM:SS BCD countdown timer and its tick synchronizer.
// Combinational helpers only (no latency); no backpressure.
// Holds the state encoding, digit layout and the load clamp used by every stage.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } timer_state_t;

    localparam int BCD_W        = 4;
    localparam int NUM_DIGITS   = 4;
    localparam int DIG_SEC_ONES = 0;
    localparam int DIG_SEC_TENS = 1;
    localparam int DIG_MIN_ONES = 2;
    localparam int DIG_MIN_TENS = 3;

    localparam logic [BCD_W-1:0] MAX_ONES     = 4'd9;
    localparam logic [BCD_W-1:0] MAX_SEC_TENS = 4'd5;

    typedef struct packed {
        logic [BCD_W-1:0] min_tens;
        logic [BCD_W-1:0] min_ones;
        logic [BCD_W-1:0] sec_tens;
        logic [BCD_W-1:0] sec_ones;
    } bcd_time_t;

    function automatic logic [BCD_W-1:0] get_digit(
        input logic [NUM_DIGITS*BCD_W-1:0] value,
        input int                          idx
    );
        return value[idx*BCD_W +: BCD_W];
    endfunction

    // Out-of-range digits saturate so the borrow chain never sees an illegal BCD code.
    function automatic logic [NUM_DIGITS*BCD_W-1:0] clamp_load(
        input logic [NUM_DIGITS*BCD_W-1:0] raw
    );
        logic [NUM_DIGITS*BCD_W-1:0] res;
        logic [BCD_W-1:0]            dig;
        res = raw;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dig = raw[i*BCD_W +: BCD_W];
            if (dig > MAX_ONES) begin
                dig = MAX_ONES;
            end
            if ((i == DIG_SEC_TENS) && (dig > MAX_SEC_TENS)) begin
                dig = MAX_SEC_TENS;
            end
            res[i*BCD_W +: BCD_W] = dig;
        end
        return res;
    endfunction

endpackage

// File: rtl/tick_sync_edge.sv
// Synchronizes the divider square wave into clk_in and emits a one-cycle rising-edge pulse.
// Latency: SYNC_STAGES+1 cycles from sig_in rise to rise_pulse (pulse is registered).
// No backpressure; a second rise arriving before the first is seen is unsupported.
module tick_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic sig_in,
    output logic rise_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            hist_q     <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], sig_in};
            hist_q     <= synced;
            rise_pulse <= synced & ~hist_q;
        end
    end

endmodule

// File: rtl/tick_countdown_timer.sv
// MM:SS BCD countdown timer stepped by the synchronized 1 Hz divider output.
// Latency: tick_in rise to time_bcd update is SYNC_STAGES+2 cycles; commands act on the next edge.
// No backpressure; commands are single-cycle pulses resolved clear > load > start_stop > tick.
module tick_countdown_timer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        tick_in,
    input  logic        load,
    input  logic [15:0] load_bcd,
    input  logic        start_stop,
    input  logic        clear,
    output logic [15:0] time_bcd,
    output logic        running,
    output logic        done,
    output logic        expired
);
    import timer_pkg::*;

    timer_state_t state_q, state_nx;
    logic [15:0]  time_q, time_nx;
    logic         expired_q, expired_nx;
    logic         tick_pulse;

    tick_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_tick_sync (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .sig_in    (tick_in),
        .rise_pulse(tick_pulse)
    );

    // Per-digit decrement with ripple borrow from seconds up to tens of minutes.
    logic [BCD_W-1:0] cur_so, cur_st, cur_mo, cur_mt;
    logic             bor_so, bor_st, bor_mo;
    bcd_time_t        time_dec;

    assign cur_so = get_digit(time_q, DIG_SEC_ONES);
    assign cur_st = get_digit(time_q, DIG_SEC_TENS);
    assign cur_mo = get_digit(time_q, DIG_MIN_ONES);
    assign cur_mt = get_digit(time_q, DIG_MIN_TENS);

    assign bor_so = (cur_so == '0);
    assign bor_st = bor_so && (cur_st == '0);
    assign bor_mo = bor_st && (cur_mo == '0);

    assign time_dec.sec_ones = bor_so ? MAX_ONES : cur_so - 4'd1;
    assign time_dec.sec_tens = !bor_so ? cur_st :
                               (cur_st == '0) ? MAX_SEC_TENS : cur_st - 4'd1;
    assign time_dec.min_ones = !bor_st ? cur_mo :
                               (cur_mo == '0) ? MAX_ONES : cur_mo - 4'd1;
    // RUN never holds 0000, so min_tens cannot underflow here.
    assign time_dec.min_tens = bor_mo ? cur_mt - 4'd1 : cur_mt;

    always_comb begin
        state_nx = state_q;
        time_nx  = time_q;
        if (clear) begin
            state_nx = ST_IDLE;
            time_nx  = '0;
        end else if (load) begin
            if (state_q != ST_RUN) begin
                state_nx = ST_IDLE;
                time_nx  = clamp_load(load_bcd);
            end
        end else if (start_stop) begin
            case (state_q)
                ST_IDLE, ST_PAUSED: begin
                    if (time_q != '0) begin
                        state_nx = ST_RUN;
                    end
                end
                ST_RUN:  state_nx = ST_PAUSED;
                default: state_nx = state_q;
            endcase
        end else if (tick_pulse && (state_q == ST_RUN)) begin
            time_nx = time_dec;
            if (time_dec == '0) begin
                state_nx = ST_DONE;
            end
        end
        expired_nx = (state_nx == ST_DONE) && (state_q != ST_DONE);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            time_q    <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_nx;
            time_q    <= time_nx;
            expired_q <= expired_nx;
        end
    end

    assign time_bcd = time_q;
    assign running  = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign expired  = expired_q;

endmodule

// File: tb/tb_tick_countdown_timer.sv
// Scenario bench for tick_countdown_timer: scoreboard of expected time values, MM:SS seconds model.
module tb_tick_countdown_timer;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        tick_in;
    logic        load;
    logic [15:0] load_bcd;
    logic        start_stop;
    logic        clear;
    logic [15:0] time_bcd;
    logic        running;
    logic        done;
    logic        expired;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];
    logic [15:0] model = 16'h0000;

    always #5 clk_in = ~clk_in;

    tick_countdown_timer #(.SYNC_STAGES(2)) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .tick_in   (tick_in),
        .load      (load),
        .load_bcd  (load_bcd),
        .start_stop(start_stop),
        .clear     (clear),
        .time_bcd  (time_bcd),
        .running   (running),
        .done      (done),
        .expired   (expired)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got time_bcd=%h required finish", time_bcd);
        $fatal(1);
    end

    // Independent model: convert to total seconds, subtract one, convert back.
    function automatic logic [15:0] dec_model(input logic [15:0] v);
        int s;
        logic [15:0] r;
        s = int'(v[15:12]) * 600 + int'(v[11:8]) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]) - 1;
        r[15:12] = 4'(s / 600);
        r[11:8]  = 4'((s % 600) / 60);
        r[7:4]   = 4'((s % 60) / 10);
        r[3:0]   = 4'(s % 10);
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v, input logic [15:0] e, input string nm);
        logic [15:0] got;
        exp_q.push_back(e);
        load_bcd = v;
        load = 1'b1;
        cyc();
        load = 1'b0;
        got = exp_q.pop_front();
        total++;
        if (time_bcd !== got) begin
            bad++;
            $display("FAIL %s: time_bcd=%h required %h", nm, time_bcd, got);
        end
        model = got;
    endtask

    task automatic do_ss(input logic exp_run, input string nm);
        start_stop = 1'b1;
        cyc();
        start_stop = 1'b0;
        total++;
        if (running !== exp_run) begin
            bad++;
            $display("FAIL %s: running=%b required %b", nm, running, exp_run);
        end
    endtask

    task automatic do_clear(input string nm);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        model = 16'h0000;
        total++;
        if ({time_bcd, running, done} !== {16'h0000, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL %s: time=%h run=%b done=%b required 0000/0/0", nm, time_bcd, running, done);
        end
    endtask

    // One tick_in period of 10 cycles; the value must update exactly 4 cycles after the rise.
    task automatic send_tick(input bit dec, input string nm);
        logic [15:0] e;
        logic [15:0] got;
        e = dec ? dec_model(model) : model;
        exp_q.push_back(e);
        tick_in = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            if (c == 3) begin
                total++;
                if (time_bcd !== model) begin
                    bad++;
                    $display("FAIL %s_early: time_bcd=%h required %h", nm, time_bcd, model);
                end
            end
            if (c == 4) begin
                got = exp_q.pop_front();
                model = got;
                total++;
                if (time_bcd !== got) begin
                    bad++;
                    $display("FAIL %s: time_bcd=%h required %h", nm, time_bcd, got);
                end
                if (dec && got == 16'h0000) begin
                    total++;
                    if ({expired, done, running} !== 3'b110) begin
                        bad++;
                        $display("FAIL %s_expire: exp/done/run=%b%b%b required 110", nm, expired, done, running);
                    end
                end
            end
            if (c == 5) begin
                tick_in = 1'b0;
                total++;
                if (expired !== 1'b0) begin
                    bad++;
                    $display("FAIL %s_expired_len: expired=%b required 0", nm, expired);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick_in = 1'b0;
        load = 1'b0;
        load_bcd = 16'h0000;
        start_stop = 1'b0;
        clear = 1'b0;
        #3;
        total++;
        if ({time_bcd, running, done, expired} !== 19'h0) begin
            bad++;
            $display("FAIL reset: time=%h run=%b done=%b exp=%b required 0", time_bcd, running, done, expired);
        end
        repeat (2) @(negedge clk_in);
        rst_n = 1'b1;
        cyc();
        total++;
        if ({time_bcd, running, done, expired} !== 19'h0) begin
            bad++;
            $display("FAIL reset_release: time=%h run=%b done=%b exp=%b required 0", time_bcd, running, done, expired);
        end
    endtask

    task automatic test_load();
        do_load(16'h0102, 16'h0102, "load_0102");
        total++;
        if ({running, done} !== 2'b00) begin
            bad++;
            $display("FAIL load_idle: run=%b done=%b required 00", running, done);
        end
        do_load(16'hA7F3, 16'h9753, "load_clamp");
        do_load(16'hFFFF, 16'h9959, "load_clamp_all");
    endtask

    task automatic test_countdown();
        do_load(16'h0100, 16'h0100, "cd_load");
        do_ss(1'b1, "cd_start");
        send_tick(1'b1, "cd_tick1");
        send_tick(1'b1, "cd_tick2");
        send_tick(1'b1, "cd_tick3");
        do_load(16'h0900, 16'h0057, "cd_load_in_run");
        do_load(16'h1000, 16'h0057, "cd_load_in_run2");
        do_clear("cd_clear");
    endtask

    task automatic test_expiry();
        do_load(16'h0002, 16'h0002, "ex_load");
        do_ss(1'b1, "ex_start");
        send_tick(1'b1, "ex_tick1");
        send_tick(1'b1, "ex_tick2");
        send_tick(1'b0, "ex_tick_done");
        do_ss(1'b0, "ex_ss_done");
        total++;
        if ({time_bcd, done} !== {16'h0000, 1'b1}) begin
            bad++;
            $display("FAIL ex_hold: time=%h done=%b required 0000/1", time_bcd, done);
        end
        do_load(16'h1000, 16'h1000, "ex_reload");
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL ex_reload_done: done=%b required 0", done);
        end
    endtask

    task automatic test_pause_resume();
        logic [15:0] got;
        do_load(16'h0010, 16'h0010, "pr_load");
        do_ss(1'b1, "pr_start");
        exp_q.push_back(model);
        tick_in = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            if (c == 4) start_stop = 1'b1;
            cyc();
            if (c == 4) begin
                start_stop = 1'b0;
                got = exp_q.pop_front();
                total++;
                if ({time_bcd, running, done} !== {got, 1'b0, 1'b0}) begin
                    bad++;
                    $display("FAIL pr_same_cycle: time=%h run=%b done=%b required %h/0/0", time_bcd, running, done, got);
                end
            end
            if (c == 5) tick_in = 1'b0;
        end
        send_tick(1'b0, "pr_paused_tick1");
        send_tick(1'b0, "pr_paused_tick2");
        do_ss(1'b1, "pr_resume");
        send_tick(1'b1, "pr_resume_tick");
    endtask

    task automatic test_priority();
        clear = 1'b1;
        load = 1'b1;
        load_bcd = 16'h0345;
        cyc();
        clear = 1'b0;
        load = 1'b0;
        model = 16'h0000;
        total++;
        if ({time_bcd, running} !== {16'h0000, 1'b0}) begin
            bad++;
            $display("FAIL prio_clear_load: time=%h run=%b required 0000/0", time_bcd, running);
        end
        do_ss(1'b0, "prio_ss_zero");
        send_tick(1'b0, "prio_idle_tick");
    endtask

    task automatic test_async_reset();
        do_load(16'h0530, 16'h0530, "ar_load");
        do_ss(1'b1, "ar_start");
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({time_bcd, running, done, expired} !== 19'h0) begin
            bad++;
            $display("FAIL async_reset: time=%h run=%b done=%b exp=%b required 0", time_bcd, running, done, expired);
        end
        @(negedge clk_in);
        rst_n = 1'b1;
        cyc();
        model = 16'h0000;
        send_tick(1'b0, "ar_tick_after");
        do_load(16'h0530, 16'h0530, "ar_reload");
        send_tick(1'b0, "ar_tick_no_start");
        total++;
        if (running !== 1'b0) begin
            bad++;
            $display("FAIL ar_not_running: running=%b required 0", running);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_countdown();
        test_expiry();
        test_pause_resume();
        test_priority();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tick_countdown_timer.md
# tick_countdown_timer

Countdown timer in MM:SS BCD, advanced by the slow square wave from the upstream 1 Hz clock divider. The divider output is treated as data: it is synchronized into the `clk_in` domain and edge-detected, so all logic runs on a single clock. The block sits between the divider and the seven-segment display/alarm logic. It provides load, start/pause, clear and an expiry indication.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth for `tick_in`; legal values are 2 or more.
- `clk_in`, input, 1: system clock; all flops use the rising edge.
- `rst_n`, input, 1: asynchronous reset, active-low; deassertion is synchronous to `clk_in` externally.
- `tick_in`, input, 1: divider output square wave; each rising edge is one second.
- `load`, input, 1: single-cycle pulse; captures `load_bcd`.
- `load_bcd`, input, 16: {min_tens, min_ones, sec_tens, sec_ones}, 4 bits each.
- `start_stop`, input, 1: single-cycle pulse; toggles between run and pause.
- `clear`, input, 1: single-cycle pulse; forces 00:00 and IDLE.
- `time_bcd`, output, 16: current value, same digit order as `load_bcd`.
- `running`, output, 1: high in RUN.
- `done`, output, 1: high in DONE.
- `expired`, output, 1: one-cycle pulse on entry to DONE.

## Operation
- **States:** IDLE, RUN, PAUSED, DONE.
- **Reset:** state is IDLE, `time_bcd` is 16'h0000, `running`, `done` and `expired` are 0, and all synchronizer flops are 0.
- **Tick pulse:** `tick_in` passes through `SYNC_STAGES` flops plus one history flop. The pulse is high for one cycle when the synced signal is 1 and the history flop is 0.
- **Command priority:** `clear` > `load` > `start_stop` > tick pulse. Only the highest-priority event present in a cycle acts.
- **`clear`:** from any state, go to IDLE with value 0000.
- **`load`:**
  - Accepted in IDLE, PAUSED and DONE; the next state is IDLE.
  - Ignored in RUN.
  - Digits are clamped on capture: any digit > 9 becomes 9, and sec_tens > 5 becomes 5.
  - Example: load 16'hA7F3 stores 16'h9753.
- **`start_stop`:**
  - IDLE or PAUSED goes to RUN if value ≠ 0000; otherwise it is ignored.
  - RUN goes to PAUSED.
  - DONE ignores it.
- **Tick in RUN:** decrement by one second.
  - sec_ones: 0 wraps to 9 and borrows.
  - sec_tens: 0 wraps to 5 and borrows.
  - min_ones: 0 wraps to 9 and borrows.
  - min_tens decrements.
  - If the result is 0000, go to DONE.
- Tick pulses in IDLE, PAUSED and DONE are discarded.
- **Resume:** the first decrement after PAUSED→RUN occurs on the next tick pulse. The partial second is not preserved.
- **Same-cycle `start_stop` and tick in RUN:** the state goes to PAUSED and no decrement occurs.
- DONE holds 0000 until `load` or `clear`.

## Timing
- All outputs are registered.
- Latency from a `tick_in` rising edge to the `time_bcd` update is `SYNC_STAGES`+2 `clk_in` cycles (4 at default).
- `running`, `done` and `expired` change in the same cycle as the state register.
- `expired` is high for exactly one cycle, coincident with `time_bcd`=0000 and `done` rising.
- Command pulses take effect on the next clock edge: the state or value is visible one cycle after the pulse.
- **Reset mid-operation:** the asynchronous assert immediately returns all outputs to their reset values. A partially synchronized tick is lost.
- `tick_in` period must exceed 2×(`SYNC_STAGES`+2) `clk_in` cycles. Any faster input is unsupported.

## Structure
- **Shared package `timer_pkg`:**
  - State encoding constants (IDLE=0, RUN=1, PAUSED=2, DONE=3).
  - `BCD_W`=4 and digit index constants.
  - Max-digit constants (9, 5).
- **Sub-module `tick_sync_edge`:**
  - Parameter `SYNC_STAGES`.
  - Ports `clk_in`, `rst_n`, `sig_in`, `rise_pulse`.
  - Reused by other stages consuming the divider output.
- **Top level:** FSM, a clamped load path, and a 4-digit BCD borrow chain written as per-digit combinational next-value logic.

## Test plan
- **Reset and load:** reset, then load 16'h0102 → `time_bcd`=0102, IDLE, `running`=0. Load 16'hA7F3 → 9753.
- **Countdown with borrows:** load 0100, `start_stop`, 3 ticks → 0059, 0058, 0057. Each update arrives exactly 4 cycles after a `tick_in` rise.
- **Expiry:** load 0002, run, 2 ticks → 0000, `done`=1, `expired` high for one cycle, `running`=0. Further ticks and `start_stop` → no change.
- **Pause and resume:** run from 0010. Assert `start_stop` in the same cycle as a tick pulse → PAUSED, value 0010. Ticks while paused → no change. Resume, one tick → 0009.
- **Priority and ignores:**
  - `load` while in RUN → ignored.
  - `clear` and `load` in the same cycle → 0000, IDLE.
  - `start_stop` at 0000 → stays IDLE.
- **Async reset mid-run:** pulse `rst_n` low between clock edges while in RUN at 0530 → outputs go to 0 immediately. After release, a tick with no start → no decrement.
